mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request/memory address width.
REQ-002 SHALL have parameter LINE_W, default 256, meaning cache-line data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles to wait for mem_ack_i.
REQ-004 SHALL have port clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req0_enable_i / req1_enable_i, input, width 1: request valid for port 0 (I-cache) / port 1 (D-cache).
REQ-007 SHALL have ports req0_write_i / req1_write_i, input, width 1: 1 = line write, 0 = line read.
REQ-008 SHALL have ports req0_addr_i / req1_addr_i, input, width ADDR_W: line address.
REQ-009 SHALL have ports req0_data_i / req1_data_i, input, width LINE_W: write line.
REQ-010 SHALL have ports req0_ack_o / req1_ack_o, output, width 1: one-cycle completion pulse.
REQ-011 SHALL have ports req0_data_o / req1_data_o, output, width LINE_W: read line, valid while the matching ack is high.
REQ-012 SHALL have ports mem_enable_o, mem_write_o (output, 1), mem_addr_o (output, ADDR_W) and mem_data_o (output, LINE_W): memory request.
REQ-013 SHALL have ports mem_ack_i (input, 1) and mem_data_i (input, LINE_W): memory completion and read data.
REQ-014 SHALL have port gnt_o, output, width 2: one-hot current owner; 00 when idle.
REQ-015 SHALL have port err_o, output, width 1: sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 In IDLE, with any enable sampled high, SHALL select the winner, latch its write/addr/data into registers driving mem_*_o, set mem_enable_o=1 and set gnt_o; next state SHALL be BUSY.
REQ-018 Arbitration SHALL be round-robin between the two ports: with both requesting, the port not granted last SHALL win; with a single requester, that port SHALL win.
REQ-019 The last-grant pointer SHALL update only on grant.
REQ-020 In BUSY, mem_enable_o and the latched mem_* outputs SHALL remain stable; requester inputs SHALL be ignored.
REQ-021 In BUSY, with mem_ack_i=1, SHALL latch mem_data_i (reads and writes alike), clear mem_enable_o and go to DONE.
REQ-022 In DONE, exactly the granted port's ack SHALL be 1 for one cycle and its data_o SHALL equal the latched line; the other port's ack SHALL be 0; next state SHALL be IDLE with gnt_o=00.
REQ-023 Request-to-ack latency SHALL be N+2 cycles, where N is the number of BUSY cycles up to and including the mem_ack_i cycle.
REQ-024 A new grant SHALL NOT occur in DONE; the earliest next mem_enable_o rise SHALL be one IDLE cycle after DONE.
REQ-025 A 9-bit-minimum BUSY cycle counter SHALL clear on entry to BUSY.
REQ-026 If the counter reaches TIMEOUT without mem_ack_i, SHALL set err_o=1, clear mem_enable_o, latch an all-zero line and go to DONE, acking the owner as in REQ-022.
REQ-027 mem_ack_i arriving in the same cycle as the timeout SHALL take precedence: normal completion, err_o unchanged.
REQ-028 mem_ack_i seen in IDLE or DONE SHALL be ignored.
REQ-029 err_o SHALL clear only on reset.
REQ-030 Ack outputs and gnt_o SHALL be register-driven: no combinational path from inputs to outputs.

Reset
REQ-031 Asserting rst_i low at any time, including mid-BUSY, SHALL immediately force IDLE.
REQ-032 On reset, all outputs SHALL be zero (mem_*_o, req*_ack_o, req*_data_o, gnt_o, err_o), the counter SHALL be zero and the last-grant pointer SHALL be 1, so port 0 wins the first tie.
REQ-033 An in-flight transaction aborted by reset SHALL produce no ack.

Verification
REQ-034 Port 0 read only, addr 0x0000_0000, memory acks after 10 cycles with 0x0000_1111...FFFF -> mem_write_o=0, req0_ack_o pulses once with that line, gnt_o=01 throughout BUSY.
REQ-035 Both ports request in the same cycle after reset -> port 0 served first, then port 1 (addr 0x200 write, data 0x0123...3210 on mem_data_o); a repeated tie then grants port 0 again.
REQ-036 Port 1 held continuously high -> port 0 request gets the next grant after port 1's DONE, proving no starvation.
REQ-037 Memory never acks -> after TIMEOUT BUSY cycles err_o=1, owner ack with zero line, mem_enable_o=0.
REQ-038 rst_i low mid-BUSY -> all outputs 0 asynchronously, no ack; after release, port 0 wins a tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of one line-wide memory port shared by
// the I-cache (port 0) and D-cache (port 1), with a sticky ack timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [LINE_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [LINE_W-1:0] req0_data_o,
    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [LINE_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [LINE_W-1:0] req1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [1:0]        gnt_o,
    output logic              err_o
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             pick;
    logic [CNT_W-1:0] cnt_inc;
    logic             tmo;

    // Winner choice (tie goes to the port not granted last) and timeout detect
    always_comb begin
        any_req = req0_enable_i | req1_enable_i;
        pick    = (req0_enable_i & req1_enable_i) ? ~last : req1_enable_i;
        cnt_inc = cnt + CNT_W'(1);
        tmo     = (cnt_inc == CNT_W'(TIMEOUT));
    end

    // Grant / wait-for-memory / ack sequencer; all outputs are registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            last         <= 1'b1;
            cnt          <= '0;
            gnt_o        <= 2'b00;
            err_o        <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            req0_ack_o   <= 1'b0;
            req1_ack_o   <= 1'b0;
            req0_data_o  <= '0;
            req1_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= BUSY;
                        last         <= pick;
                        cnt          <= '0;
                        gnt_o        <= pick ? 2'b10 : 2'b01;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= pick ? req1_write_i : req0_write_i;
                        mem_addr_o   <= pick ? req1_addr_i : req0_addr_i;
                        mem_data_o   <= pick ? req1_data_i : req0_data_i;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state        <= DONE;
                        mem_enable_o <= 1'b0;
                        if (gnt_o[1]) begin
                            req1_ack_o  <= 1'b1;
                            req1_data_o <= mem_data_i;
                        end else begin
                            req0_ack_o  <= 1'b1;
                            req0_data_o <= mem_data_i;
                        end
                    end else if (tmo) begin
                        state        <= DONE;
                        mem_enable_o <= 1'b0;
                        err_o        <= 1'b1;
                        if (gnt_o[1]) begin
                            req1_ack_o  <= 1'b1;
                            req1_data_o <= '0;
                        end else begin
                            req0_ack_o  <= 1'b1;
                            req0_data_o <= '0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    gnt_o       <= 2'b00;
                    req0_ack_o  <= 1'b0;
                    req1_ack_o  <= 1'b0;
                    req0_data_o <= '0;
                    req1_data_o <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scenarios for mem_arbiter checked against a
// round-robin / latency / timeout reference model kept in the bench.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int TIMEOUT = 255;

    localparam logic [LINE_W-1:0] LINE_A =
        256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [LINE_W-1:0] LINE_B =
        256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req0_enable_i, req1_enable_i;
    logic              req0_write_i, req1_write_i;
    logic [ADDR_W-1:0] req0_addr_i, req1_addr_i;
    logic [LINE_W-1:0] req0_data_i, req1_data_i;
    logic              req0_ack_o, req1_ack_o;
    logic [LINE_W-1:0] req0_data_o, req1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;
    logic [1:0]        gnt_o;
    logic              err_o;

    logic [ADDR_W+3*LINE_W+6:0] all_outs;
    assign all_outs = {mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
                       req0_ack_o, req1_ack_o, req0_data_o, req1_data_o,
                       gnt_o, err_o};

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_enable_i(req0_enable_i),
        .req0_write_i (req0_write_i),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req0_ack_o   (req0_ack_o),
        .req0_data_o  (req0_data_o),
        .req1_enable_i(req1_enable_i),
        .req1_write_i (req1_write_i),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .req1_ack_o   (req1_ack_o),
        .req1_data_o  (req1_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .gnt_o        (gnt_o),
        .err_o        (err_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    int nchk = 0;
    int nfail = 0;

    // Reference model state
    int m_last;
    bit m_err;

    // Requester stimulus for the next transaction, and the memory line
    bit                w0, w1;
    logic [ADDR_W-1:0] a0, a1;
    logic [LINE_W-1:0] d0, d1, mline;

    // Observations captured by run_txn
    logic [1:0]        o_gnt, o_gnt_idle, o_ack_idle;
    logic              o_en, o_wr, o_stable, o_ack0, o_ack1;
    logic              o_en_done, o_err, o_en_idle;
    logic [ADDR_W-1:0] o_addr;
    logic [LINE_W-1:0] o_data, o_rdata;
    int                o_lat;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Round-robin rule: on a tie the port not granted last wins
    function automatic int rr_win(bit e0, bit e1);
        if (e0 && e1) return 1 - m_last;
        return e1 ? 1 : 0;
    endfunction

    function automatic logic [1:0] onehot(int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    // Drive one transaction from an IDLE negedge; memory acks in BUSY
    // cycle 'delay' (0 = never). Ends at the IDLE negedge after DONE.
    task automatic run_txn(input bit e0, input bit e1,
                           input bit e0b, input bit e1b, input int delay);
        bit got;
        int edges;
        req0_enable_i = e0;
        req1_enable_i = e1;
        req0_write_i  = w0;
        req1_write_i  = w1;
        req0_addr_i   = a0;
        req1_addr_i   = a1;
        req0_data_i   = d0;
        req1_data_i   = d1;
        @(negedge clk_i);
        o_gnt  = gnt_o;
        o_en   = mem_enable_o;
        o_wr   = mem_write_o;
        o_addr = mem_addr_o;
        o_data = mem_data_o;
        req0_enable_i = e0b;
        req1_enable_i = e1b;
        o_stable = 1'b1;
        got      = 1'b0;
        edges    = 1;
        for (int cyc = 1; cyc <= TIMEOUT + 5 && !got; cyc++) begin
            if (cyc == delay) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mline;
            end
            req0_addr_i  = ADDR_W'($urandom);
            req1_addr_i  = ADDR_W'($urandom);
            req0_write_i = 1'($urandom);
            req1_write_i = 1'($urandom);
            req0_data_i  = rand_line();
            req1_data_i  = rand_line();
            @(negedge clk_i);
            edges++;
            mem_ack_i  = 1'b0;
            mem_data_i = rand_line();
            if (req0_ack_o || req1_ack_o) got = 1'b1;
            else if ({gnt_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o}
                     !== {o_gnt, o_en, o_wr, o_addr, o_data})
                o_stable = 1'b0;
        end
        o_lat     = got ? edges + 1 : -1;
        o_ack0    = req0_ack_o;
        o_ack1    = req1_ack_o;
        o_rdata   = req1_ack_o ? req1_data_o : req0_data_o;
        o_en_done = mem_enable_o;
        o_err     = err_o;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i  = 1'b0;
        o_gnt_idle = gnt_o;
        o_ack_idle = {req1_ack_o, req0_ack_o};
        o_en_idle  = mem_enable_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req0_enable_i = 0; req1_enable_i = 0;
        req0_write_i = 0;  req1_write_i = 0;
        req0_addr_i = '0;  req1_addr_i = '0;
        req0_data_i = '0;  req1_data_i = '0;
        mem_ack_i = 0;     mem_data_i = '0;
        w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; mline = '0;
        repeat (3) @(negedge clk_i);
        nchk++;
        if (all_outs !== '0) begin
            nfail++;
            $display("FAIL reset_outs: got %0h want 0", all_outs);
        end
        rst_i = 1'b1;
        m_last = 1;
        m_err  = 0;
        repeat (2) @(negedge clk_i);
        nchk++;
        if (all_outs !== '0) begin
            nfail++;
            $display("FAIL idle_no_req: got %0h want 0", all_outs);
        end
    endtask

    task automatic test_port0_read();
        int w;
        a0 = '0; w0 = 0; d0 = rand_line(); mline = LINE_A;
        w = rr_win(1, 0); m_last = w;
        run_txn(1, 0, 0, 0, 10);
        nchk++;
        if (o_gnt !== 2'b01) begin
            nfail++; $display("FAIL p0_gnt: got %b want 01", o_gnt);
        end
        nchk++;
        if ({o_en, o_wr, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
            nfail++; $display("FAIL p0_memreq: en/wr/addr %b/%b/%h", o_en, o_wr, o_addr);
        end
        nchk++;
        if (o_stable !== 1'b1) begin
            nfail++; $display("FAIL p0_busy_stable: got %b want 1", o_stable);
        end
        nchk++;
        if (o_lat != 12) begin
            nfail++; $display("FAIL p0_latency: got %0d want 12", o_lat);
        end
        nchk++;
        if ({o_ack1, o_ack0, o_rdata} !== {2'b01, LINE_A}) begin
            nfail++; $display("FAIL p0_ack: acks %b%b data %h want 01 %h", o_ack1, o_ack0, o_rdata, LINE_A);
        end
        nchk++;
        if ({o_gnt_idle, o_ack_idle, o_en_idle} !== 5'b0) begin
            nfail++; $display("FAIL p0_after: gnt %b acks %b en %b want 0", o_gnt_idle, o_ack_idle, o_en_idle);
        end
    endtask

    task automatic test_tie();
        int w;
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        m_last = 1; m_err = 0;
        a0 = ADDR_W'($urandom); w0 = 0; d0 = rand_line();
        a1 = 32'h200; w1 = 1; d1 = LINE_B;
        for (int k = 0; k < 3; k++) begin
            mline = rand_line();
            w = rr_win(1, 1); m_last = w;
            run_txn(1, 1, k < 2, k < 2, 2 + k);
            nchk++;
            if (o_gnt !== onehot(w)) begin
                nfail++; $display("FAIL tie%0d_gnt: got %b want %b", k, o_gnt, onehot(w));
            end
            nchk++;
            if ({o_ack1, o_ack0} !== onehot(w) || o_rdata !== mline || o_lat != 4 + k) begin
                nfail++; $display("FAIL tie%0d_ack: acks %b%b lat %0d want %b lat %0d", k, o_ack1, o_ack0, o_lat, onehot(w), 4 + k);
            end
            if (k == 1) begin
                nchk++;
                if ({o_wr, o_addr, o_data} !== {1'b1, 32'h200, LINE_B}) begin
                    nfail++; $display("FAIL tie_p1_write: wr %b addr %h data %h", o_wr, o_addr, o_data);
                end
            end
        end
    endtask

    task automatic test_no_starve();
        int w;
        bit ok;
        ok = 1'b1;
        mline = rand_line();
        w = rr_win(0, 1); m_last = w;
        run_txn(0, 1, 1, 1, 5);
        if (o_gnt !== onehot(w) || o_en_idle !== 1'b0 || o_gnt_idle !== 2'b00) ok = 1'b0;
        w = rr_win(1, 1); m_last = w;
        run_txn(1, 1, 1, 1, 2);
        nchk++;
        if (!ok || o_gnt !== 2'b01 || w != 0 || o_lat != 4) begin
            nfail++; $display("FAIL no_starve: gnt %b lat %0d ok %b want 01 lat 4", o_gnt, o_lat, ok);
        end
        w = rr_win(1, 1); m_last = w;
        run_txn(1, 1, 0, 0, 1);
        nchk++;
        if (o_gnt !== onehot(w)) begin
            nfail++; $display("FAIL no_starve_alt: got %b want %b", o_gnt, onehot(w));
        end
    endtask

    task automatic test_random();
        int w, dly;
        bit e0, e1;
        logic [1:0] e, eb;
        for (int k = 0; k < 24; k++) begin
            e  = 2'($urandom_range(1, 3));
            eb = 2'($urandom_range(0, 3));
            e0 = e[0]; e1 = e[1];
            w0 = 1'($urandom); w1 = 1'($urandom);
            a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom);
            d0 = rand_line(); d1 = rand_line(); mline = rand_line();
            dly = $urandom_range(1, 12);
            w = rr_win(e0, e1); m_last = w;
            run_txn(e0, e1, eb[0], eb[1], dly);
            nchk++;
            if (o_gnt !== onehot(w)) begin
                nfail++; $display("FAIL rnd%0d_gnt: got %b want %b", k, o_gnt, onehot(w));
            end
            nchk++;
            if ({o_en, o_wr, o_addr, o_data} !== (w == 1 ? {1'b1, w1, a1, d1} : {1'b1, w0, a0, d0})) begin
                nfail++; $display("FAIL rnd%0d_memreq: wr %b addr %h", k, o_wr, o_addr);
            end
            nchk++;
            if (o_stable !== 1'b1) begin
                nfail++; $display("FAIL rnd%0d_stable: got %b want 1", k, o_stable);
            end
            nchk++;
            if (o_lat != dly + 2) begin
                nfail++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, o_lat, dly + 2);
            end
            nchk++;
            if ({o_ack1, o_ack0} !== onehot(w) || o_rdata !== mline || o_en_done !== 1'b0) begin
                nfail++; $display("FAIL rnd%0d_ack: acks %b%b en %b data %h want %h", k, o_ack1, o_ack0, o_en_done, o_rdata, mline);
            end
            nchk++;
            if ({o_gnt_idle, o_ack_idle, o_en_idle, o_err} !== {5'b0, m_err}) begin
                nfail++; $display("FAIL rnd%0d_after: gnt %b acks %b en %b err %b", k, o_gnt_idle, o_ack_idle, o_en_idle, o_err);
            end
        end
    endtask

    task automatic test_stray_ack();
        bit ok;
        ok = 1'b1;
        req0_enable_i = 0; req1_enable_i = 0;
        mem_ack_i = 1'b1;
        mem_data_i = rand_line();
        repeat (4) begin
            @(negedge clk_i);
            if ({gnt_o, req0_ack_o, req1_ack_o, mem_enable_o} !== 5'b0) ok = 1'b0;
        end
        mem_ack_i = 1'b0;
        nchk++;
        if (!ok) begin
            nfail++; $display("FAIL stray_ack: got activity %b want none", ok);
        end
    endtask

    task automatic test_timeout_edge();
        a0 = ADDR_W'($urandom); w0 = 0; mline = rand_line();
        m_last = rr_win(1, 0);
        run_txn(1, 0, 0, 0, TIMEOUT);
        nchk++;
        if (o_lat != TIMEOUT + 2 || o_err !== 1'b0 || o_rdata !== mline || o_ack0 !== 1'b1) begin
            nfail++; $display("FAIL tmo_edge: lat %0d err %b ack0 %b want lat %0d err 0", o_lat, o_err, o_ack0, TIMEOUT + 2);
        end
    endtask

    task automatic test_timeout();
        a1 = ADDR_W'($urandom); w1 = 1; mline = rand_line();
        m_last = rr_win(0, 1);
        m_err = 1;
        run_txn(0, 1, 0, 0, 0);
        nchk++;
        if (o_lat != TIMEOUT + 2) begin
            nfail++; $display("FAIL tmo_latency: got %0d want %0d", o_lat, TIMEOUT + 2);
        end
        nchk++;
        if ({o_ack1, o_ack0, o_err, o_en_done} !== 4'b1010 || o_rdata !== '0) begin
            nfail++; $display("FAIL tmo_done: acks %b%b err %b en %b data %h", o_ack1, o_ack0, o_err, o_en_done, o_rdata);
        end
    endtask

    task automatic test_err_sticky();
        a0 = ADDR_W'($urandom); mline = rand_line();
        m_last = rr_win(1, 0);
        run_txn(1, 0, 0, 0, 3);
        nchk++;
        if (o_err !== m_err || o_rdata !== mline || o_lat != 5) begin
            nfail++; $display("FAIL err_sticky: err %b lat %0d want err %b lat 5", o_err, o_lat, m_err);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        int w;
        a0 = ADDR_W'($urandom); d0 = rand_line();
        req0_enable_i = 1; req1_enable_i = 0;
        req0_addr_i = a0; req0_data_i = d0; req0_write_i = 0;
        @(negedge clk_i);
        req0_enable_i = 0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_data_i = rand_line();
        #1;
        nchk++;
        if (all_outs !== '0) begin
            nfail++; $display("FAIL rst_async: got %0h want 0", all_outs);
        end
        m_last = 1; m_err = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            if ({gnt_o, req0_ack_o, req1_ack_o, mem_enable_o, err_o} !== 6'b0) ok = 1'b0;
        end
        mem_ack_i = 1'b0;
        nchk++;
        if (!ok) begin
            nfail++; $display("FAIL rst_no_ack: got activity after abort");
        end
        a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom); mline = rand_line();
        w = rr_win(1, 1); m_last = w;
        run_txn(1, 1, 0, 0, 2);
        nchk++;
        if (o_gnt !== onehot(w) || o_gnt !== 2'b01 || o_err !== 1'b0) begin
            nfail++; $display("FAIL rst_tie: gnt %b err %b want 01 0", o_gnt, o_err);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_port0_read();
        test_tie();
        test_no_starve();
        test_random();
        test_stray_ack();
        test_timeout_edge();
        test_timeout();
        test_err_sticky();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    // Overall time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
